lfsr_param: RTL and testbench
=============================

LFSR_PARAM -- requirements
Module: lfsr_param

Interface
REQ-001 Parameter WIDTH, default 16, LFSR length in bits; legal range 3..32; elaboration fails outside it.
REQ-002 Parameter OUT_W, default 16, number of state bits presented on lfsr_out; legal range 1..WIDTH.
REQ-003 Parameter SEED_DEFAULT, default 1, WIDTH-bit state and seed value applied at reset.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 load  input  1  capture seed into the state and seed registers this edge.
REQ-007 seed  input  WIDTH  seed value, sampled only when load=1.
REQ-008 enable  input  1  advance the LFSR by one step this edge.
REQ-009 lfsr_out  output  OUT_W  state[OUT_W-1:0].
REQ-010 lfsr_done  output  1  one-cycle pulse marking return to the captured seed.
REQ-011 lockup  output  1  state is all-ones, the XNOR lock-up state.
REQ-012 period_len  output  WIDTH  step count of the last completed cycle; 0 until one completes.

Function
REQ-013 Update priority per edge is rst, then load, then enable; with all three low, all registers hold.
REQ-014 Tap position n (1-based) maps to state[n-1].
REQ-015 Feedback is the XNOR of the tap bits for WIDTH, using the maximal-length table {3:3,2; 4:4,3; 5:5,3; 6:6,5; 7:7,6; 8:8,6,5,4; 9:9,5; 10:10,7; 11:11,9; 12:12,6,4,1; 13:13,4,3,1; 14:14,5,3,1; 15:15,14; 16:16,15,13,4; 17:17,14; 18:18,11; 19:19,6,2,1; 20:20,17; 21:21,19; 22:22,21; 23:23,18; 24:24,23,22,17; 25:25,22; 26:26,6,2,1; 27:27,5,2,1; 28:28,25; 29:29,27; 30:30,6,4,1; 31:31,28; 32:32,22,2,1}.
REQ-016 Step: state <= {state[WIDTH-2:0], feedback}.
REQ-017 load: state <= seed and seed_q <= seed; lfsr_out shows the seed on the cycle after the load edge (latency 1).
REQ-018 load: step counter <= 0 and lfsr_done <= 0; period_len holds its value.
REQ-019 enable with load=0: step counter increments by 1.
REQ-020 When the next state equals seed_q, the same edge registers lfsr_done=1, period_len <= counter+1, and counter <= 0.
REQ-021 lfsr_done is high for exactly one cycle per return to the seed; continuous enable produces a pulse every 2^WIDTH-1 steps.
REQ-022 Counter width is WIDTH bits; the maximum period 2^WIDTH-1 fits without overflow, and no wrap handling beyond REQ-020 is required.
REQ-023 lockup is a combinational decode of state == all-ones.
REQ-024 In lockup, stepping leaves the state at all-ones and lfsr_done pulses on every enabled step (period_len=1); load is the only exit besides rst.
REQ-025 An all-ones seed is accepted as-is; no substitution.
REQ-026 load and enable together: load wins and no step occurs.

Reset
REQ-027 On rst=1 at an edge: state <= SEED_DEFAULT, seed_q <= SEED_DEFAULT, counter <= 0, lfsr_done <= 0, period_len <= 0.
REQ-028 rst asserted mid-cycle-count discards progress; after release, the sequence restarts from SEED_DEFAULT.

Structure
REQ-029 Shared package lfsr_pkg holds the tap table as a function that returns a 32-bit tap mask for a given width, plus the constants LFSR_MIN_W=3 and LFSR_MAX_W=32.
REQ-030 Feedback is computed as the reduction-XNOR of (state AND mask); no sub-module is needed, and the block is a single module.

Verification
REQ-031 WIDTH=4, load seed=0, enable continuous -> lfsr_out sequence 1,3,7,E,D,...; lfsr_done pulses after step 15; period_len=15.
REQ-032 WIDTH=16, seed=16'hACE1, enable continuous -> lfsr_done pulses after 65535 steps; period_len=65535; lockup never asserts.
REQ-033 WIDTH=5, load seed=5'h1F -> lockup=1; each enabled step keeps state 1F, pulses lfsr_done, and sets period_len=1.
REQ-034 load=1 and enable=1 on the same edge with seed=8'h3C (WIDTH=8) -> next lfsr_out=3C, counter=0, no step.
REQ-035 rst pulsed after 100 steps (WIDTH=8, SEED_DEFAULT=1) -> next cycle lfsr_out=01, lfsr_done=0, period_len=0.
REQ-036 Sweep WIDTH 3..20 from seed 0 -> measured period_len equals 2^WIDTH-1 for each width.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared constants and the maximal-length tap table for the XNOR LFSR.
// Tap n (1-based) maps to mask bit n-1.
package lfsr_pkg;

    localparam int LFSR_MIN_W = 3;
    localparam int LFSR_MAX_W = 32;

    function automatic logic [31:0] tap_bit(input int n);
        return 32'd1 << (n - 1);
    endfunction

    function automatic logic [31:0] lfsr_tap_mask(input int width);
        logic [31:0] m;
        m = '0;
        case (width)
            3:  m = tap_bit(3)  | tap_bit(2);
            4:  m = tap_bit(4)  | tap_bit(3);
            5:  m = tap_bit(5)  | tap_bit(3);
            6:  m = tap_bit(6)  | tap_bit(5);
            7:  m = tap_bit(7)  | tap_bit(6);
            8:  m = tap_bit(8)  | tap_bit(6)  | tap_bit(5)  | tap_bit(4);
            9:  m = tap_bit(9)  | tap_bit(5);
            10: m = tap_bit(10) | tap_bit(7);
            11: m = tap_bit(11) | tap_bit(9);
            12: m = tap_bit(12) | tap_bit(6)  | tap_bit(4)  | tap_bit(1);
            13: m = tap_bit(13) | tap_bit(4)  | tap_bit(3)  | tap_bit(1);
            14: m = tap_bit(14) | tap_bit(5)  | tap_bit(3)  | tap_bit(1);
            15: m = tap_bit(15) | tap_bit(14);
            16: m = tap_bit(16) | tap_bit(15) | tap_bit(13) | tap_bit(4);
            17: m = tap_bit(17) | tap_bit(14);
            18: m = tap_bit(18) | tap_bit(11);
            19: m = tap_bit(19) | tap_bit(6)  | tap_bit(2)  | tap_bit(1);
            20: m = tap_bit(20) | tap_bit(17);
            21: m = tap_bit(21) | tap_bit(19);
            22: m = tap_bit(22) | tap_bit(21);
            23: m = tap_bit(23) | tap_bit(18);
            24: m = tap_bit(24) | tap_bit(23) | tap_bit(22) | tap_bit(17);
            25: m = tap_bit(25) | tap_bit(22);
            26: m = tap_bit(26) | tap_bit(6)  | tap_bit(2)  | tap_bit(1);
            27: m = tap_bit(27) | tap_bit(5)  | tap_bit(2)  | tap_bit(1);
            28: m = tap_bit(28) | tap_bit(25);
            29: m = tap_bit(29) | tap_bit(27);
            30: m = tap_bit(30) | tap_bit(6)  | tap_bit(4)  | tap_bit(1);
            31: m = tap_bit(31) | tap_bit(28);
            32: m = tap_bit(32) | tap_bit(22) | tap_bit(2)  | tap_bit(1);
            default: m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lfsr_param.sv
// Parameterised XNOR Fibonacci LFSR with seed capture, return-to-seed pulse,
// measured period length and all-ones lock-up decode.
module lfsr_param
    import lfsr_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int OUT_W = 16,
    parameter logic [WIDTH-1:0] SEED_DEFAULT = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             enable,
    output logic [OUT_W-1:0] lfsr_out,
    output logic             lfsr_done,
    output logic             lockup,
    output logic [WIDTH-1:0] period_len
);

    generate
        if (WIDTH < LFSR_MIN_W || WIDTH > LFSR_MAX_W) begin : g_bad_width
            $error("lfsr_param: WIDTH out of range");
        end
        if (OUT_W < 1 || OUT_W > WIDTH) begin : g_bad_out_w
            $error("lfsr_param: OUT_W out of range");
        end
    endgenerate

    localparam logic [WIDTH-1:0] TAP_MASK = WIDTH'(lfsr_tap_mask(WIDTH));
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] r_seed_q;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_period;
    logic             r_done;

    logic             w_feedback;
    logic [WIDTH-1:0] w_next;
    logic             w_hit;

    // XNOR feedback keeps all-zeros inside the sequence; all-ones is the stuck state.
    assign w_feedback = ~^(r_state & TAP_MASK);
    assign w_next     = {r_state[WIDTH-2:0], w_feedback};
    assign w_hit      = (w_next == r_seed_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= SEED_DEFAULT;
            r_seed_q <= SEED_DEFAULT;
            r_count  <= '0;
            r_done   <= 1'b0;
            r_period <= '0;
        end else if (load) begin
            r_state  <= seed;
            r_seed_q <= seed;
            r_count  <= '0;
            r_done   <= 1'b0;
        end else if (enable) begin
            r_state <= w_next;
            if (w_hit) begin
                r_done   <= 1'b1;
                r_period <= r_count + ONE;
                r_count  <= '0;
            end else begin
                r_done  <= 1'b0;
                r_count <= r_count + ONE;
            end
        end else begin
            // The done flag is a pulse, so it drops even while everything else holds.
            r_done <= 1'b0;
        end
    end

    assign lfsr_out   = r_state[OUT_W-1:0];
    assign lfsr_done  = r_done;
    assign lockup     = &r_state;
    assign period_len = r_period;

endmodule

// File: tb/tb_lfsr_param.sv
// Bench for lfsr_param: randomized WIDTH=8 run against a tap-list model via a
// scoreboard queue, plus parallel full-period sweeps for WIDTH 3..14.
module tb_lfsr_param;

  logic clk;
  int   checks   = 0;
  int   failures = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- main DUT: WIDTH=8, OUT_W=6 ----------------
  logic       rst, load, enable;
  logic [7:0] seed;
  logic [5:0] lfsr_out;
  logic       lfsr_done, lockup;
  logic [7:0] period_len;

  lfsr_param #(.WIDTH(8), .OUT_W(6), .SEED_DEFAULT(8'h01)) u_dut (
    .clk(clk), .rst(rst), .load(load), .seed(seed), .enable(enable),
    .lfsr_out(lfsr_out), .lfsr_done(lfsr_done), .lockup(lockup),
    .period_len(period_len)
  );

  typedef struct packed {
    logic [5:0] out;
    logic       done;
    logic       lk;
    logic [7:0] per;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state
  logic [7:0] m_st, m_sq, m_cnt, m_per;
  logic       m_done;
  int         taps8[4] = '{8, 6, 5, 4};

  function automatic logic [7:0] model_step(input logic [7:0] s);
    logic p;
    p = 1'b0;
    foreach (taps8[i]) p = p ^ s[taps8[i]-1];
    return {s[6:0], ~p};
  endfunction

  task automatic drive(input bit r, input bit l, input logic [7:0] s, input bit e);
    logic [7:0] nx;
    exp_t x;
    @(negedge clk);
    rst = r; load = l; seed = s; enable = e;
    if (r) begin
      m_st = 8'h01; m_sq = 8'h01; m_cnt = 0; m_done = 0; m_per = 0;
    end else if (l) begin
      m_st = s; m_sq = s; m_cnt = 0; m_done = 0;
    end else if (e) begin
      nx = model_step(m_st);
      if (nx == m_sq) begin
        m_done = 1; m_per = m_cnt + 8'd1; m_cnt = 0;
      end else begin
        m_done = 0; m_cnt = m_cnt + 8'd1;
      end
      m_st = nx;
    end else begin
      m_done = 0;
    end
    x.out  = m_st[5:0];
    x.done = m_done;
    x.lk   = (m_st == 8'hFF);
    x.per  = m_per;
    exp_q.push_back(x);
  endtask

  // Monitor: pops one expectation per edge that had stimulus behind it
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("lfsr_out",   32'(lfsr_out),   32'(e.out));
        check("lfsr_done",  32'(lfsr_done),  32'(e.done));
        check("lockup",     32'(lockup),     32'(e.lk));
        check("period_len", 32'(period_len), 32'(e.per));
      end
    end
  end

  // ---------------- sweep DUTs: WIDTH 3..14 from seed 0 ----------------
  logic      sw_rst = 1'b0, sw_load = 1'b0, sw_en = 1'b0;
  bit        sw_go = 1'b0;
  bit [14:0] sw_fin = '0;

  for (genvar w = 3; w <= 14; w++) begin : g_sweep
    logic [w-1:0] o;
    logic         d, lk;
    logic [w-1:0] p;
    int           steps;
    bit           seen, lk_seen;

    lfsr_param #(.WIDTH(w), .OUT_W(w)) u (
      .clk(clk), .rst(sw_rst), .load(sw_load), .seed({w{1'b0}}), .enable(sw_en),
      .lfsr_out(o), .lfsr_done(d), .lockup(lk), .period_len(p)
    );

    initial begin
      wait (sw_go);
      steps = 0; seen = 0; lk_seen = 0;
      while (!seen && steps < (1 << w) + 8) begin
        @(posedge clk);
        #1;
        steps++;
        if (lk) lk_seen = 1;
        if (d) seen = 1;
      end
      check($sformatf("sweep%0d_done_step", w), seen ? steps : 0, (1 << w) - 1);
      check($sformatf("sweep%0d_period", w), 32'(p), (1 << w) - 1);
      check($sformatf("sweep%0d_lockup", w), 32'(lk_seen), 0);
      sw_fin[w] = 1'b1;
    end
  end

  initial begin
    @(negedge clk); sw_rst = 1'b1;
    @(negedge clk); sw_rst = 1'b0; sw_load = 1'b1;
    @(negedge clk); sw_load = 1'b0; sw_en = 1'b1; sw_go = 1'b1;
  end

  // WIDTH=4 sequence from seed 0
  initial begin
    logic [3:0] seq4[5];
    seq4 = '{4'h1, 4'h3, 4'h7, 4'hE, 4'hD};
    wait (sw_go);
    #1;
    check("w4_loaded", 32'(g_sweep[4].o), 0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("w4_seq%0d", i), 32'(g_sweep[4].o), 32'(seq4[i]));
    end
  end

  // ---------------- main stimulus ----------------
  initial begin
    bit         r, l, e;
    logic [7:0] s;
    int         budget;
    rst = 1'b0; load = 1'b0; seed = '0; enable = 1'b0;

    drive(1, 0, 8'h00, 0);
    drive(1, 0, 8'h00, 1);
    drive(0, 0, 8'h00, 0);

    // Random mix of reset, load and enable
    for (int i = 0; i < 300; i++) begin
      r = ($urandom_range(0, 49) == 0);
      l = ($urandom_range(0, 9) == 0);
      s = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      e = ($urandom_range(0, 3) != 0);
      drive(r, l, s, e);
    end

    // load and enable together: load wins
    drive(0, 1, 8'h3C, 1);
    for (int i = 0; i < 3; i++) drive(0, 0, 8'h00, 1);

    // reset after 100 steps
    drive(1, 0, 8'h00, 0);
    for (int i = 0; i < 100; i++) drive(0, 0, 8'($urandom), 1);
    drive(1, 0, 8'h00, 1);
    drive(0, 0, 8'h00, 0);

    // random seed, long run to see two full periods
    s = 8'($urandom_range(0, 254));
    drive(0, 1, s, 0);
    for (int i = 0; i < 520; i++) drive(0, 0, 8'($urandom), 1);

    // all-ones seed sticks
    drive(0, 1, 8'hFF, 0);
    for (int i = 0; i < 5; i++) drive(0, 0, 8'h00, 1);
    drive(0, 0, 8'h00, 0);
    drive(0, 1, 8'h00, 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 8'h00, 1);

    // hold with everything low
    for (int i = 0; i < 4; i++) drive(0, 0, 8'($urandom), 0);

    budget = 0;
    while ((sw_fin[14:3] != '1 || exp_q.size() != 0) && budget < 20000) begin
      @(posedge clk);
      budget++;
    end
    check("sweep_finished", 32'(sw_fin[14:3]), 32'(12'hFFF));
    check("queue_drained", exp_q.size(), 0);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
